// File: rtl/reg_serial_port.sv
// Parallel-request front end for the bit-serial register file: one 32-cycle rotate pass per request.
// Optional REG_SERIAL_PORT_HAZARD_STALL_EN adds a read-only pass ahead of writes that read their own rd.
module reg_serial_port #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_rs1,
  input  logic [SEL_W-1:0] req_rs2,
  input  logic [SEL_W-1:0] req_rd,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata1,
  output logic [WIDTH-1:0] rsp_rdata2,
  output logic [SEL_W-1:0] rf_r_sel1,
  output logic [SEL_W-1:0] rf_r_sel2,
  input  logic             rf_r_value1,
  input  logic             rf_r_value2,
  output logic [SEL_W-1:0] rf_write_register,
  output logic             rf_write_value,
  output logic             rf_wr_en,
  output logic             rf_shift
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_DONE
`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
    , S_HAZ
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [CNT_W-1:0] wbit;
  logic             capture_en;
`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
  logic             frozen_q, frozen_d;
  logic             hazard;

  assign hazard = req_we && (req_rd != '0) && ((req_rs1 == req_rd) || (req_rs2 == req_rd));
`endif

  // The file inserts the written bit at position 1 and then rotates it 31-cnt more times,
  // so bits are fed in the order 0,31,30..1 to land each one in place at the end of the pass.
  assign wbit = CNT_W'(WIDTH - int'(cnt_q));

  // NOTE: every next-state value and output gets a default first, so no path through the case
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    rs1_d             = rs1_q;
    rs2_d             = rs2_q;
    rd_d              = rd_q;
    we_d              = we_q;
    wdata_d           = wdata_q;
    rdata1_d          = rdata1_q;
    rdata2_d          = rdata2_q;
    req_ready         = 1'b0;
    rsp_valid         = 1'b0;
    rf_r_sel1         = '0;
    rf_r_sel2         = '0;
    rf_write_register = '0;
    rf_write_value    = 1'b0;
    rf_wr_en          = 1'b0;
    rf_shift          = 1'b0;
`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
    frozen_d          = frozen_q;
    capture_en        = !frozen_q;
`else
    capture_en        = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rd_d    = req_rd;
          we_d    = req_we;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = S_PASS;
`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
          frozen_d = 1'b0;
          if (hazard) state_d = S_HAZ;
`endif
        end
      end

`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
      // Read-only pass: captures the clean old values before the write pass disturbs them.
      S_HAZ: begin
        rf_shift          = 1'b1;
        rf_r_sel1         = rs1_q;
        rf_r_sel2         = rs2_q;
        rf_write_register = rd_q;
        rdata1_d          = {rdata1_q[WIDTH-2:0], rf_r_value1};
        rdata2_d          = {rdata2_q[WIDTH-2:0], rf_r_value2};
        cnt_d             = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_PASS;
          frozen_d = 1'b1;
        end
      end
`endif

      S_PASS: begin
        rf_shift          = 1'b1;
        rf_r_sel1         = rs1_q;
        rf_r_sel2         = rs2_q;
        rf_write_register = rd_q;
        rf_wr_en          = we_q && (rd_q != '0);
        rf_write_value    = wdata_q[wbit];
        if (capture_en) begin
          rdata1_d = {rdata1_q[WIDTH-2:0], rf_r_value1};
          rdata2_d = {rdata2_q[WIDTH-2:0], rf_r_value2};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
      frozen_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
      frozen_q <= frozen_d;
`endif
    end
  end

  assign rsp_rdata1 = rdata1_q;
  assign rsp_rdata2 = rdata2_q;

endmodule

// File: tb/tb_reg_serial_port.sv
// Bench for reg_serial_port: bit-serial register file model plus a word-level reference of
// register contents, latency and write-bit ordering; honours REG_SERIAL_PORT_HAZARD_STALL_EN.
module tb_reg_serial_port;
  localparam int WIDTH = 32;
  localparam int SEL_W = 4;
`ifdef REG_SERIAL_PORT_HAZARD_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [SEL_W-1:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
  logic             req_we = 1'b0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata1, rsp_rdata2;
  logic [SEL_W-1:0] rf_r_sel1, rf_r_sel2, rf_write_register;
  logic             rf_r_value1, rf_r_value2;
  logic             rf_write_value, rf_wr_en, rf_shift;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_serial_port #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_rs1          (req_rs1),
    .req_rs2          (req_rs2),
    .req_rd           (req_rd),
    .req_we           (req_we),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata1       (rsp_rdata1),
    .rsp_rdata2       (rsp_rdata2),
    .rf_r_sel1        (rf_r_sel1),
    .rf_r_sel2        (rf_r_sel2),
    .rf_r_value1      (rf_r_value1),
    .rf_r_value2      (rf_r_value2),
    .rf_write_register(rf_write_register),
    .rf_write_value   (rf_write_value),
    .rf_wr_en         (rf_wr_en),
    .rf_shift         (rf_shift)
  );

  // Bit-serial register file: rotate left per shift; a write drops the bit in at position 1.
  logic [WIDTH-1:0] rf_mem [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (rf_shift) begin
      for (int i = 1; i < 16; i++) begin
        if (rf_wr_en && rf_write_register == 4'(i))
          rf_mem[i] <= {rf_mem[i][30:1], rf_write_value, rf_mem[i][31]};
        else
          rf_mem[i] <= {rf_mem[i][30:0], rf_mem[i][31]};
      end
    end
  end
  assign rf_r_value1 = (rf_r_sel1 == '0) ? 1'b0 : rf_mem[rf_r_sel1][31];
  assign rf_r_value2 = (rf_r_sel2 == '0) ? 1'b0 : rf_mem[rf_r_sel2][31];

  // Architectural view of the register file contents.
  logic [WIDTH-1:0] ref_regs [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge and follow it to its response.
  task automatic run_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic we, input logic [31:0] wd, input bit hold, output int waited);
    logic [31:0] e1, e2, wbits;
    bit          writes, haz, got_rsp;
    int          lat, wstart, k, wen_cnt, shift_cnt, busy_ready;

    writes = we && (rd != 0);
    haz    = writes && (rs1 == rd || rs2 == rd);
    e1     = (rs1 == 0) ? 32'h0 : ref_regs[rs1];
    e2     = (rs2 == 0) ? 32'h0 : ref_regs[rs2];
    if (!STALL && writes) begin
      if (rs1 == rd) e1 = {e1[31:1], wd[0]};
      if (rs2 == rd) e2 = {e2[31:1], wd[0]};
    end
    lat    = (STALL && haz) ? 65 : 33;
    wstart = lat - 32;
    if (writes) ref_regs[rd] = wd;

    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_we = we; req_wdata = wd;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;

    k = 0; got_rsp = 0; wen_cnt = 0; shift_cnt = 0; busy_ready = 0; wbits = '0;
    while (k < 100 && !got_rsp) begin
      @(negedge clk);
      k++;
      if (rsp_valid) got_rsp = 1;
      else begin
        wen_cnt   += int'(rf_wr_en);
        shift_cnt += int'(rf_shift);
        if (req_ready) busy_ready++;
        if (k >= wstart && k < wstart + 32) wbits[(32 - (k - wstart)) % 32] = rf_write_value;
      end
    end
    check("latency", 32'(k), 32'(lat));
    check("rdata1", rsp_rdata1, e1);
    check("rdata2", rsp_rdata2, e2);
    check("wr_en_cycles", 32'(wen_cnt), writes ? 32'd32 : 32'd0);
    check("shift_cycles", 32'(shift_cnt), 32'(lat - 1));
    check("ready_while_busy", 32'(busy_ready), 32'd0);
    if (writes) check("write_bit_order", wbits, wd);
  endtask

  initial begin
    int          w;
    logic [3:0]  a, b, d;
    logic [31:0] v;

    $display("*** STALL build = %0d ***", STALL);
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata1", rsp_rdata1, 32'h0);
    check("reset_rdata2", rsp_rdata2, 32'h0);
    check("reset_rf_outputs", 32'({rf_r_sel1, rf_r_sel2, rf_write_register,
                                   rf_write_value, rf_wr_en, rf_shift}), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read, with x0 on the second port.
    run_req(4'd0, 4'd0, 4'd3, 1'b1, 32'hDEADBEEF, 1'b0, w);
    run_req(4'd3, 4'd0, 4'd0, 1'b0, 32'h0, 1'b0, w);
    // Write to x0 must never strobe, and x0 still reads zero.
    run_req(4'd0, 4'd0, 4'd0, 1'b1, 32'hFFFFFFFF, 1'b0, w);
    run_req(4'd0, 4'd3, 4'd0, 1'b0, 32'h0, 1'b0, w);
    // Read-during-write on the same register.
    run_req(4'd0, 4'd0, 4'd5, 1'b1, 32'h12345678, 1'b0, w);
    run_req(4'd5, 4'd0, 4'd5, 1'b1, 32'h0000000F, 1'b0, w);
    run_req(4'd5, 4'd5, 4'd0, 1'b0, 32'h0, 1'b0, w);
    // Endpoint bits of the write ordering.
    run_req(4'd0, 4'd0, 4'd7, 1'b1, 32'h80000001, 1'b0, w);
    run_req(4'd7, 4'd3, 4'd0, 1'b0, 32'h0, 1'b0, w);
    // Valid held through a pass: next request goes in on the first IDLE cycle.
    run_req(4'd7, 4'd5, 4'd11, 1'b1, 32'hA5A5_0F0F, 1'b1, w);
    run_req(4'd11, 4'd3, 4'd0, 1'b0, 32'h0, 1'b0, w);
    check("back_to_back_wait", 32'(w), 32'd1);

    // Randomized traffic, biased toward read-during-write.
    for (int n = 0; n < 30; n++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15));
      v = $urandom;
      run_req(a, b, d, 1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)), w);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a pass.
    run_req(4'd0, 4'd0, 4'd9, 1'b1, 32'hCAFE_F00D, 1'b0, w);
    @(negedge clk);
    req_rs1 = 4'd9; req_rs2 = 4'd3; req_rd = 4'd0; req_we = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_reset_shift", 32'(rf_shift), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midpass_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midpass_rst_rf_outputs", 32'({rf_r_sel1, rf_r_sel2, rf_write_register,
                                         rf_write_value, rf_wr_en, rf_shift}), 32'h0);
    check("midpass_rst_rdata1", rsp_rdata1, 32'h0);
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 32'd1);
    run_req(4'd9, 4'd3, 4'd0, 1'b0, 32'h0, 1'b0, w);
    run_req(4'd11, 4'd7, 4'd0, 1'b0, 32'h0, 1'b0, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
